denorm_shift_pipe: RTL and testbench
====================================

DENORM_SHIFT_PIPE -- requirements
Module: denorm_shift_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset.
REQ-002 Parameter PRODWIDTH, default 48: width of the normalized mantissa product.
REQ-003 Parameter WEXPSUM, default 10: width of the two's-complement exponent.
REQ-004 Parameter GUARDWIDTH, default 3: zero bits appended below the product. SHIFTWIDTH = PRODWIDTH+GUARDWIDTH.
REQ-005 Parameter TAGW, default 4: width of the pass-through tag (channel/sequence ID).
REQ-006 Ports, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  input item present
- in_ready  out  1  input item accepted when in_valid&in_ready
- normalized  in  PRODWIDTH  normalized product
- selectedexp  in  WEXPSUM  signed exponent
- in_tag  in  TAGW  tag
- out_valid  out  1  output item present
- out_ready  in  1  downstream accepts
- shiftprod  out  SHIFTWIDTH  shifted significand
- shiftexp  out  WEXPSUM  resulting exponent
- shiftloss  out  1  nonzero bits lost or sticky
- out_tag  out  TAGW  tag of output item
- tozero_flag  out  1  item fully shifted out

Function
REQ-007 Two register stages (S1: decode, S2: shift/sticky); latency exactly 2 cycles from acceptance to out_valid when never stalled; throughput 1 item/cycle.
REQ-008 S1 SHALL register preshift = {normalized, GUARDWIDTH zeros}, tag, doshift, tozero, and the clamped amount.
REQ-009 doshift = 1 iff selectedexp <= 0 (signed); amount = -selectedexp, computed in WEXPSUM+1 bits so the most-negative exponent does not wrap.
REQ-010 tozero = doshift & (amount > SHIFTWIDTH); the amount is then clamped to SHIFTWIDTH.
REQ-011 S2: doshift=1 -> shiftprod = preshift >> amount, shiftexp = 0; doshift=0 -> shiftprod = preshift, shiftexp = selectedexp, shiftloss = 0.
REQ-012 shiftloss = tozero | (doshift & (OR of the GUARDWIDTH LSBs of shiftprod | OR of all bits shifted below bit 0)).
REQ-013 tozero_flag = tozero of the output item; when tozero, shiftprod = 0.
REQ-014 Each stage holds its item while the next stage is full and not advancing. S2 advances when out_ready or ~out_valid. in_ready = ~S1_valid | S1 advancing. Combinational paths are allowed in_ready <- out_ready only.
REQ-015 out_valid and all output data SHALL stay stable while out_valid & ~out_ready.
REQ-016 flush=1 invalidates S1 and S2 at the next edge. in_ready = 0 while flush=1, so an input presented with flush is not accepted; flush overrides out_ready.
REQ-017 Items and tags SHALL leave in acceptance order with no drop or duplication under any out_ready pattern.

Reset
REQ-018 While rst_n=0: out_valid=0, S1_valid=0, shiftprod=0, shiftexp=0, shiftloss=0, out_tag=0, tozero_flag=0.
REQ-019 Assertion mid-operation discards all in-flight items immediately.
REQ-020 After deassertion, in_ready=1 in the first cycle.

Configuration
REQ-021 Macro DENORM_FTZ_EN:
- defined: any doshift item outputs shiftprod=0 and shiftexp=0, with shiftloss = |normalized and tozero_flag=1 (flush-to-zero).
- undefined: gradual denormalization per REQ-011..013.
- Ports and latency are identical in both cases.

Verification (PRODWIDTH=8, GUARDWIDTH=4, WEXPSUM=6, FTZ off)
REQ-022 normalized=8'hB4, exp=6'h3E(-2) -> 2 cycles later shiftprod=12'h2D0, shiftexp=0, shiftloss=0.
REQ-023 normalized=8'hB4, exp=-5 -> shiftprod=12'h05A, shiftloss=1. exp=+3 -> shiftprod=12'hB40, shiftexp=3, shiftloss=0.
REQ-024 exp=-20 and exp=6'h20(-32), normalized=8'h80 -> shiftprod=0, shiftloss=1, tozero_flag=1 (no wrap at -32).
REQ-025 Back-to-back 4 items, tags 1..4, out_ready held low 3 cycles -> in_ready drops after 2 items held; outputs tags 1..4 in order, data stable while stalled.
REQ-026 flush with items in both stages and in_valid=1 -> next cycle out_valid=0, input not accepted. rst_n pulsed low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/denorm_shift_pipe.sv
// Two-stage denormalizing right shifter with sticky/loss detection.
// Optional flush-to-zero build: define DENORM_FTZ_EN.
module denorm_shift_pipe #(
  parameter int PRODWIDTH  = 48,
  parameter int WEXPSUM    = 10,
  parameter int GUARDWIDTH = 3,
  parameter int TAGW       = 4,
  localparam int SHIFTWIDTH = PRODWIDTH + GUARDWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PRODWIDTH-1:0]  normalized,
  input  logic [WEXPSUM-1:0]    selectedexp,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SHIFTWIDTH-1:0] shiftprod,
  output logic [WEXPSUM-1:0]    shiftexp,
  output logic                  shiftloss,
  output logic [TAGW-1:0]       out_tag,
  output logic                  tozero_flag
);

  localparam int AW = $clog2(SHIFTWIDTH + 1);

  typedef struct packed {
    logic [SHIFTWIDTH-1:0] preshift;
    logic [WEXPSUM-1:0]    exp;
    logic [TAGW-1:0]       tag;
    logic                  doshift;
    logic                  tozero;
    logic [AW-1:0]         amt;
  } s1_t;

  typedef struct packed {
    logic [SHIFTWIDTH-1:0] prod;
    logic [WEXPSUM-1:0]    exp;
    logic                  loss;
    logic [TAGW-1:0]       tag;
    logic                  tozero;
  } s2_t;

  s1_t s1_d;
  s1_t s1_q;
  s2_t s2_d;
  s2_t s2_q;
  logic s1_valid;
  logic s2_adv;

  logic signed [WEXPSUM:0] negexp;
  logic [31:0]             amtw;
  logic [SHIFTWIDTH-1:0]   shifted;
  logic [SHIFTWIDTH-1:0]   lostmask;

  // One extra bit so negating the most-negative exponent cannot wrap.
  assign negexp = -$signed({selectedexp[WEXPSUM-1], selectedexp});
  assign amtw   = 32'(negexp);

  always_comb begin
    s1_d          = '0;
    s1_d.preshift = {normalized, {GUARDWIDTH{1'b0}}};
    s1_d.exp      = selectedexp;
    s1_d.tag      = in_tag;
    s1_d.doshift  = selectedexp[WEXPSUM-1] | (selectedexp == '0);
    s1_d.tozero   = s1_d.doshift & (amtw > 32'(SHIFTWIDTH));
    unique case (1'b1)
      !s1_d.doshift: s1_d.amt = '0;
      s1_d.tozero:   s1_d.amt = AW'(SHIFTWIDTH);
      default:       s1_d.amt = AW'(amtw);
    endcase
  end

  assign shifted  = s1_q.preshift >> s1_q.amt;
  assign lostmask = ~({SHIFTWIDTH{1'b1}} << s1_q.amt);

  always_comb begin
    s2_d        = '0;
    s2_d.tag    = s1_q.tag;
    s2_d.tozero = s1_q.tozero;
    if (!s1_q.doshift) begin
      s2_d.prod = s1_q.preshift;
      s2_d.exp  = s1_q.exp;
    end else begin
`ifdef DENORM_FTZ_EN
      s2_d.loss   = |s1_q.preshift;
      s2_d.tozero = 1'b1;
`else
      if (s1_q.tozero) begin
        s2_d.loss = 1'b1;
      end else begin
        s2_d.prod = shifted;
        s2_d.loss = (|shifted[GUARDWIDTH-1:0])
                  | (|(s1_q.preshift & lostmask));
      end
`endif
    end
  end

  assign s2_adv   = out_ready | ~out_valid;
  assign in_ready = ~flush & (~s1_valid | s2_adv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      s2_q      <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
    end
  end

  assign shiftprod   = s2_q.prod;
  assign shiftexp    = s2_q.exp;
  assign shiftloss   = s2_q.loss;
  assign out_tag     = s2_q.tag;
  assign tozero_flag = s2_q.tozero;

endmodule

// File: tb/tb_denorm_shift_pipe.sv
// Self-checking bench for denorm_shift_pipe (8-bit product, 4 guard bits,
// 6-bit exponent) with an arithmetic reference model.
module tb_denorm_shift_pipe;

  localparam int SW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  normalized = '0;
  logic [5:0]  selectedexp = '0;
  logic [3:0]  in_tag = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] shiftprod;
  logic [5:0]  shiftexp;
  logic        shiftloss;
  logic [3:0]  out_tag;
  logic        tozero_flag;

  int checks = 0;
  int errors = 0;

  typedef logic [19:0] res_t;
  res_t got;
  assign got = {shiftprod, shiftexp, shiftloss, tozero_flag};

  typedef struct packed {
    logic [7:0] n;
    logic [5:0] e;
    res_t       r;
  } vec_t;

  typedef struct {
    res_t       r;
    logic [3:0] tag;
  } exp_t;

  denorm_shift_pipe #(
    .PRODWIDTH(8), .WEXPSUM(6), .GUARDWIDTH(4), .TAGW(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .normalized(normalized), .selectedexp(selectedexp),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .shiftprod(shiftprod), .shiftexp(shiftexp),
    .shiftloss(shiftloss), .out_tag(out_tag),
    .tozero_flag(tozero_flag)
  );

  always #5 clk = ~clk;

  // {prod, exp, loss, tozero} computed with integer arithmetic.
  function automatic res_t ref_model(input logic [7:0] n,
                                     input logic [5:0] e);
    int ev, val, amt, q;
    logic loss;
    res_t r;
    ev  = $signed(e);
    val = int'(n) * 16;
    if (ev > 0) begin
      r = {12'(val), e, 2'b00};
    end else begin
`ifdef DENORM_FTZ_EN
      r = {12'd0, 6'd0, (n != 8'd0), 1'b1};
`else
      amt = -ev;
      if (amt > SW) begin
        r = {12'd0, 6'd0, 2'b11};
      end else begin
        q    = val >> amt;
        loss = ((val % (1 << amt)) != 0) || ((q % 16) != 0);
        r    = {12'(q), 6'd0, loss, 1'b0};
      end
`endif
    end
    return r;
  endfunction

  vec_t vecs [13] = '{
    {8'hB4, 6'h3E, 12'h2D0, 6'h00, 2'b00},
    {8'hB4, 6'h3B, 12'h05A, 6'h00, 2'b10},
    {8'hB4, 6'h03, 12'hB40, 6'h03, 2'b00},
    {8'h80, 6'h2C, 12'h000, 6'h00, 2'b11},
    {8'h80, 6'h20, 12'h000, 6'h00, 2'b11},
    {8'hB4, 6'h00, 12'hB40, 6'h00, 2'b00},
    {8'h80, 6'h34, 12'h000, 6'h00, 2'b10},
    {8'h80, 6'h35, 12'h001, 6'h00, 2'b10},
    {8'h80, 6'h33, 12'h000, 6'h00, 2'b11},
    {8'hFF, 6'h1F, 12'hFF0, 6'h1F, 2'b00},
    {8'h00, 6'h2C, 12'h000, 6'h00, 2'b11},
    {8'h01, 6'h3C, 12'h001, 6'h00, 2'b10},
    {8'h00, 6'h3D, 12'h000, 6'h00, 2'b00}
  };

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, got, out_tag} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {out_valid, got, out_tag});
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    if (in_ready !== 1'b1) errors++;
    if ({out_valid, got, out_tag} !== '0) errors++;
  endtask

  task automatic test_vectors;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      normalized  = vecs[i].n;
      selectedexp = vecs[i].e;
      in_tag      = 4'(i);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_latency: out_valid %b required 0",
                 i, out_valid);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, got, out_tag} !== {1'b1, vecs[i].r, 4'(i)}) begin
        errors++;
        $display("FAIL vec%0d: got v=%b %h tag=%h required v=1 %h tag=%h",
                 i, out_valid, got, out_tag, vecs[i].r, 4'(i));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bn [4];
    logic [5:0] be [4];
    logic [23:0] snap;
    logic snap_v;
    int sent, recv;
    sent = 0;
    recv = 0;
    snap = '0;
    snap_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bn[k] = 8'($urandom);
      be[k] = 6'($urandom);
    end
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        normalized  = bn[sent];
        selectedexp = be[sent];
        in_tag      = 4'(sent + 1);
      end
      #1;
      if (cyc == 2 || cyc == 4) begin
        checks++;
        if (in_ready !== 1'b0 || sent != 2) begin
          errors++;
          $display("FAIL b2b_in_ready: in_ready=%b sent=%0d required 0/2",
                   in_ready, sent);
        end
      end
      if (out_valid && !out_ready) begin
        if (snap_v) begin
          checks++;
          if ({got, out_tag} !== snap) begin
            errors++;
            $display("FAIL b2b_stable: got %h required %h",
                     {got, out_tag}, snap);
          end
        end
        snap   = {got, out_tag};
        snap_v = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({got, out_tag} !== {ref_model(bn[recv], be[recv]),
                                4'(recv + 1)}) begin
          errors++;
          $display("FAIL b2b_item%0d: got %h tag=%h required %h tag=%h",
                   recv, got, out_tag, ref_model(bn[recv], be[recv]),
                   4'(recv + 1));
        end
        recv++;
        snap_v = 1'b0;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d items required 4", recv);
    end
  endtask

  task automatic fill_two(input logic [5:0] e);
    int sent;
    sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && sent < 2; c++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      normalized  = 8'hB4;
      selectedexp = e;
      in_tag      = 4'(c + 5);
      #1;
      if (in_ready) sent++;
    end
  endtask

  task automatic test_flush;
    fill_two(6'h3E);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: out_valid=%b in_ready=%b required 1/0",
               out_valid, in_ready);
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: out_valid %b required 0", out_valid);
    end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_s1: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_async_reset;
    fill_two(6'h03);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: out_valid %b required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, got, out_tag} !== '0) begin
      errors++;
      $display("FAIL areset_async: got %h required 0",
               {out_valid, got, out_tag});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: in_ready=%b out_valid=%b required 1/0",
               in_ready, out_valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_discard: out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_random;
    exp_t q[$];
    exp_t x;
    logic [23:0] snap;
    logic snap_v, fl;
    int seq;
    seq = 0;
    snap = '0;
    snap_v = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      fl         = ($urandom_range(0, 39) == 0);
      flush      = fl;
      out_ready  = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 2) != 0);
      normalized = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        selectedexp = 6'($urandom);
      else
        selectedexp = 6'(-int'($urandom_range(0, 14)));
      in_tag = 4'(seq);
      #1;
      if (out_valid && snap_v) begin
        checks++;
        if ({got, out_tag} !== snap) begin
          errors++;
          $display("FAIL rnd_stable: got %h required %h",
                   {got, out_tag}, snap);
        end
      end
      snap_v = out_valid && !out_ready && !fl;
      snap   = {got, out_tag};
      if (fl) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_flush_ready: in_ready %b required 0", in_ready);
        end
        q.delete();
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rnd_extra: got tag %h required no item", out_tag);
          end else begin
            x = q.pop_front();
            if ({got, out_tag} !== {x.r, x.tag}) begin
              errors++;
              $display("FAIL rnd_item: got %h tag=%h required %h tag=%h",
                       got, out_tag, x.r, x.tag);
            end
          end
        end
        if (in_valid && in_ready) begin
          x.r   = ref_model(normalized, selectedexp);
          x.tag = in_tag;
          q.push_back(x);
          seq++;
        end
      end
    end
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        x = q.pop_front();
        checks++;
        if ({got, out_tag} !== {x.r, x.tag}) begin
          errors++;
          $display("FAIL rnd_drain: got %h tag=%h required %h tag=%h",
                   got, out_tag, x.r, x.tag);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rnd_lost: %0d items missing required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
